// File: rtl/bcd_counter_multi.sv
// ============================================================================
// Module   : bcd_counter_multi
// Purpose  : Multi-digit BCD up/down counter with parallel load, count
//            enable, and wrap or saturate behaviour at the end of the range.
//            Provides a combinational carry/borrow out for cascading and a
//            registered one-cycle roll-over pulse.
// Ports    : clk       - rising-edge clock
//            reset     - synchronous reset, active-high
//            en        - count enable, one step per cycle while high
//            up        - direction, 1 = increment, 0 = decrement
//            load      - synchronous parallel load (beats en)
//            load_val  - BCD load value, digit 0 (LSD) in bits [3:0]
//            q         - registered BCD count
//            co        - carry/borrow out, combinational
//            rolled    - registered pulse, high the cycle after a wrap
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter_multi #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  co,
  output logic                  rolled
);

  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_d;
  logic                rolled_q;
  logic                rolled_d;

  logic [4*DIGITS-1:0] load_clamped;
  logic [4*DIGITS-1:0] step_val;
  logic                at_term;

  // Any load digit above 9 is forced to 9 so the count stays valid BCD.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
      logic [3:0] ld_digit;
      assign ld_digit = load_val[4*gi +: 4];
      assign load_clamped[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
    end
  endgenerate

  // Ripple step: a digit moves only when every lower digit sits at the
  // terminal value for the current direction. The running 'carry' after the
  // last digit therefore means the whole count is at its terminal value.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    carry    = 1'b1;
    step_val = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        end else begin
          step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        end
      end
      carry = carry & (up ? (dig == 4'd9) : (dig == 4'd0));
    end
    at_term = carry;
  end

  // Reset is handled in the register; everything else is decided here.
  always_comb begin
    count_d  = count_q;
    rolled_d = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      // In saturate mode the terminal value simply holds.
      if (!(at_term && SATURATE)) begin
        count_d  = step_val;
        rolled_d = at_term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      rolled_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rolled_q <= rolled_d;
    end
  end

  assign q      = count_q;
  assign rolled = rolled_q;
  // Combinational so a following stage can use it directly as its enable.
  assign co     = en & ~load & ~reset & at_term;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_multi.sv
// ============================================================================
// Module   : tb_bcd_counter_multi
// Purpose  : Self-checking bench for bcd_counter_multi. Several instances
//            (2-digit wrap, 2-digit saturate, 3-digit, 4-digit, and a pair
//            of cascaded 1-digit counters) share one stimulus stream and are
//            checked every cycle against an integer-valued reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_counter_multi;

  localparam int NI = 4;
  localparam int ND [NI] = '{2, 2, 3, 4};
  localparam bit SV [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [15:0] lv = '0;

  always #5 clk = ~clk;

  logic [7:0]  q0, q1;
  logic [11:0] q2;
  logic [15:0] q3;
  logic        co0, co1, co2, co3;
  logic        ro0, ro1, ro2, ro3;
  logic [3:0]  ql, qh;
  logic        col, coh, rol, roh;

  bcd_counter_multi #(.DIGITS(2), .SATURATE(1'b0)) u_d2w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv[7:0]), .q(q0), .co(co0), .rolled(ro0));
  bcd_counter_multi #(.DIGITS(2), .SATURATE(1'b1)) u_d2s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv[7:0]), .q(q1), .co(co1), .rolled(ro1));
  bcd_counter_multi #(.DIGITS(3), .SATURATE(1'b0)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv[11:0]), .q(q2), .co(co2), .rolled(ro2));
  bcd_counter_multi #(.DIGITS(4), .SATURATE(1'b0)) u_d4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv), .q(q3), .co(co3), .rolled(ro3));
  // Cascaded pair: the upper digit is enabled by the lower digit's co.
  bcd_counter_multi #(.DIGITS(1), .SATURATE(1'b0)) u_lo (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .q(ql), .co(col), .rolled(rol));
  bcd_counter_multi #(.DIGITS(1), .SATURATE(1'b0)) u_hi (
    .clk(clk), .reset(reset), .en(col), .up(up), .load(load),
    .load_val(lv[7:4]), .q(qh), .co(coh), .rolled(roh));

  logic [15:0] dq [NI];
  logic        dc [NI];
  logic        dr [NI];
  assign dq[0] = {8'h00, q0};  assign dc[0] = co0;  assign dr[0] = ro0;
  assign dq[1] = {8'h00, q1};  assign dc[1] = co1;  assign dr[1] = ro1;
  assign dq[2] = {4'h0, q2};   assign dc[2] = co2;  assign dr[2] = ro2;
  assign dq[3] = q3;           assign dc[3] = co3;  assign dr[3] = ro3;

  // ---------------- reference model (plain integers) ----------------------
  function automatic int maxv(int nd);
    int m;
    m = 1;
    for (int i = 0; i < nd; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [15:0] to_bcd(int v, int nd);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int clampv(logic [15:0] x, int nd);
    int r;
    int d;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'(x[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  int mv [NI];
  bit mr [NI];
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        mv[i] = 0;
        mr[i] = 1'b0;
      end else if (load) begin
        mv[i] = clampv(lv, ND[i]);
        mr[i] = 1'b0;
      end else if (en) begin
        mr[i] = 1'b0;
        if (up) begin
          if (mv[i] < maxv(ND[i])) mv[i] = mv[i] + 1;
          else if (!SV[i]) begin mv[i] = 0; mr[i] = 1'b1; end
        end else begin
          if (mv[i] > 0) mv[i] = mv[i] - 1;
          else if (!SV[i]) begin mv[i] = maxv(ND[i]); mr[i] = 1'b1; end
        end
      end else begin
        mr[i] = 1'b0;
      end
    end
    if (reset) mvalid = 1'b1;
  end

  // ---------------- hand-computed pins set by the driver -------------------
  bit          pv [NI];
  logic [15:0] pq [NI];
  bit          pr [NI];
  bit          pcv [NI];
  bit          pc [NI];
  int          pin_stamp = 0;
  int          seen_stamp = 0;

  // ---------------- compare process --------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic ec;
    logic ec0;
    ec0 = 1'b0;
    if (mvalid) begin
      for (int i = 0; i < NI; i++) begin
        ec = en & ~load & ~reset & (mv[i] == (up ? maxv(ND[i]) : 0));
        if (i == 0) ec0 = ec;
        chk($sformatf("q[%0d]", i), dq[i], to_bcd(mv[i], ND[i]));
        chk($sformatf("rolled[%0d]", i), {15'd0, dr[i]}, {15'd0, mr[i]});
        chk($sformatf("co[%0d]", i), {15'd0, dc[i]}, {15'd0, ec});
      end
      chk("cascade_q", {8'h00, qh, ql}, to_bcd(mv[0], 2));
      chk("cascade_co", {15'd0, coh}, {15'd0, ec0});
    end
    if (pin_stamp != seen_stamp) begin
      seen_stamp = pin_stamp;
      for (int i = 0; i < NI; i++) begin
        if (pv[i]) begin
          chk($sformatf("pin_q[%0d]", i), dq[i], pq[i]);
          chk($sformatf("pin_rolled[%0d]", i), {15'd0, dr[i]}, {15'd0, pr[i]});
          if (pcv[i]) chk($sformatf("pin_co[%0d]", i), {15'd0, dc[i]}, {15'd0, pc[i]});
        end
      end
    end
  end

  // ---------------- driver ------------------------------------------------
  task automatic cyc(input bit r, input bit l, input bit e, input bit u, input logic [15:0] v);
    @(posedge clk);
    #2;
    reset = r; load = l; en = e; up = u; lv = v;
    for (int i = 0; i < NI; i++) begin pv[i] = 1'b0; pcv[i] = 1'b0; end
  endtask

  task automatic pin(input int i, input logic [15:0] qv, input bit rv, input bit cvalid, input bit cv);
    pv[i] = 1'b1; pq[i] = qv; pr[i] = rv; pcv[i] = cvalid; pc[i] = cv;
  endtask

  task automatic go();
    pin_stamp++;
  endtask

  initial begin
    bit dir;
    bit r, l, e;
    logic [15:0] v;
    for (int i = 0; i < NI; i++) begin
      mv[i] = 0; mr[i] = 1'b0; pv[i] = 1'b0; pq[i] = '0;
      pr[i] = 1'b0; pcv[i] = 1'b0; pc[i] = 1'b0;
    end

    // Count up over the full 2-digit range and wrap once.
    cyc(1, 0, 0, 1, 16'h0000);
    for (int k = 0; k <= 100; k++) begin
      cyc(0, 0, 1, 1, 16'h0000);
      pin(0, {8'h00, 4'((k % 100) / 10), 4'(k % 10)}, k == 100, 1'b1, k == 99);
      go();
    end

    // Down from zero: wrap instance goes to 99, saturate instance holds 00.
    cyc(1, 0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0000);
    pin(0, 16'h0000, 1'b0, 1'b1, 1'b1);
    pin(1, 16'h0000, 1'b0, 1'b1, 1'b1);
    go();
    cyc(0, 0, 1, 0, 16'h0000);
    pin(0, 16'h0099, 1'b1, 1'b1, 1'b0);
    pin(1, 16'h0000, 1'b0, 1'b1, 1'b1);
    go();
    cyc(0, 0, 0, 0, 16'h0000);
    pin(0, 16'h0098, 1'b0, 1'b1, 1'b0);
    pin(1, 16'h0000, 1'b0, 1'b1, 1'b0);
    go();

    // Multi-digit carry and borrow on the 3-digit instance.
    cyc(0, 1, 1, 1, 16'h0199);
    cyc(0, 0, 1, 1, 16'h0000);
    pin(2, 16'h0199, 1'b0, 1'b0, 1'b0);
    go();
    cyc(0, 0, 1, 0, 16'h0000);
    pin(2, 16'h0200, 1'b0, 1'b0, 1'b0);
    go();
    cyc(0, 0, 0, 1, 16'h0000);
    pin(2, 16'h0199, 1'b0, 1'b1, 1'b0);
    go();

    // Load with a non-BCD digit while en is also high.
    cyc(0, 1, 1, 1, 16'h00A5);
    cyc(0, 0, 0, 1, 16'h0000);
    pin(0, 16'h0095, 1'b0, 1'b1, 1'b0);
    pin(3, 16'h0095, 1'b0, 1'b1, 1'b0);
    go();

    // Reset beats load and en; counting resumes from zero afterwards.
    cyc(0, 1, 0, 1, 16'h0057);
    cyc(1, 1, 1, 1, 16'h0057);
    pin(0, 16'h0057, 1'b0, 1'b0, 1'b0);
    go();
    cyc(0, 0, 1, 1, 16'h0000);
    pin(0, 16'h0000, 1'b0, 1'b1, 1'b0);
    go();
    cyc(0, 0, 1, 1, 16'h0000);
    pin(0, 16'h0001, 1'b0, 1'b0, 1'b0);
    go();
    cyc(0, 0, 0, 1, 16'h0000);
    pin(0, 16'h0002, 1'b0, 1'b0, 1'b0);
    go();

    // Randomized traffic; loads favour values near the range ends.
    dir = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 99) < 6);
      e = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 8) dir = ~dir;
      case ($urandom_range(0, 3))
        0:       v = 16'h9999;
        1:       v = 16'h0000;
        2:       v = 16'h9998;
        default: v = 16'($urandom);
      endcase
      cyc(r, l, e, dir, v);
    end
    cyc(0, 0, 0, 1, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0000);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
